string_serializer: RTL
======================

# string_serializer

Downstream consumer of the wide packed string registers that our preprocessed test designs drive (e.g. an 8*80-bit `"hello, world"` register). It captures a right-justified packed Verilog string and emits its characters MSB-first, one byte per handshake. Leading NUL padding is discarded; the first character is the first non-NUL byte. It feeds byte-oriented sinks such as a UART or log FIFO.

## Interface
- MAXCHARS, 80, string capacity in bytes; `str_in` is 8*MAXCHARS bits wide.
- CNTW, $clog2(MAXCHARS+1), width of the internal remaining-byte counter.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset: one clock, asynchronous, active-high.
- start  in  1  single-cycle load request; ignored unless idle.
- str_in  in  8*MAXCHARS  packed string; byte MAXCHARS-1 (MSBs) is first, byte 0 (LSBs) is last.
- busy  out  1  high in every state except IDLE.
- ch_valid  out  1  character available.
- ch_ready  in  1  sink accepts the character.
- ch_data  out  8  current character.
- ch_last  out  1  qualifies `ch_data` as the final byte (byte 0).
- done  out  1  one-cycle pulse at the end of every accepted job, including an empty one.

## Operation
- State machine: IDLE, SKIP, SEND, DONE.
- Datapath: shift register `sr` (8*MAXCHARS bits), counter `rem` (CNTW bits).
- IDLE:
  - `start`=1 loads `sr`<=`str_in` and `rem`<=MAXCHARS, then goes to SKIP.
  - Otherwise stays in IDLE.
- SKIP, examining the top byte `sr[8*MAXCHARS-1 -: 8]`:
  - Non-zero: go to SEND; no shift.
  - Zero: shift `sr` left 8 bits, fill with zeros, decrement `rem`. If `rem` was 1, go to DONE (all-NUL string); else stay in SKIP.
- SEND:
  - `ch_valid`=1 and `ch_data` = top byte.
  - `ch_last` = (`rem`==1).
  - On `ch_valid && ch_ready`: shift `sr` left 8, decrement `rem`. If `ch_last`, go to DONE; else stay in SEND.
  - NUL bytes after the first non-NUL byte are sent unchanged.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored. The job in flight is unaffected, and the request is neither queued nor remembered.
- `str_in` is sampled only on the cycle `start` is accepted.
- `rem` never underflows, because every exit fires when `rem`==1.

## Timing
- Reset (async assert) forces IDLE, `sr`=0, `rem`=0, and `busy`/`ch_valid`/`ch_last`/`done`/`ch_data` = 0.
- Reset deasserted: the first active edge is the first edge after deassertion.
- Reset mid-job aborts immediately:
  - No `done` pulse.
  - `ch_valid` drops asynchronously.
- All outputs are registered or decoded from state and registers only; there is no combinational path from `ch_ready` or `start` to any output.
- Let `start` be high at edge 0 and let L be the number of leading NULs:
  - SKIP occupies cycles 1..L+1.
  - `ch_valid` first rises in cycle L+2.
- Empty string: `done` in cycle MAXCHARS+1; `busy` low in cycle MAXCHARS+2.
- Throughput: one byte per cycle while `ch_ready`=1.
- Handshake: once `ch_valid` rises, it stays high and `ch_data`/`ch_last` stay stable until accepted.
- After the last accept in cycle T: `done` in cycle T+1, IDLE in T+2, and a new `start` is accepted in T+2.
- `busy` rises in cycle 1 and falls in the cycle after `done`.

## Test plan
- `"hello, world"`, MAXCHARS=80, `ch_ready` tied high, `start` at cycle 0:
  - 68 NULs are skipped.
  - `ch_valid` rises in cycle 70 with `ch_data`=0x68 ('h').
  - 12 beats are delivered in cycles 70..81; `ch_last`=1 only on 0x64 ('d') in cycle 81.
  - `done` in cycle 82; `busy`=0 in cycle 83.
- All-zero `str_in`:
  - `ch_valid` never asserts.
  - `done` in cycle 81 exactly.
- Backpressure:
  - 80 non-NUL bytes 0x01..0x50; `ch_ready` low for cycles 2..6, high from 7.
  - `ch_data`=0x01 is held stable in cycles 2..6.
  - Beats are accepted in cycles 7..86; `ch_last` on 0x50.
- Embedded NUL:
  - `str_in` = {78 NULs, 0x41, 0x00}.
  - Two beats: 0x41, then 0x00 with `ch_last`=1.
- `start` re-pulsed in cycles 5 and 70 during a job with a different `str_in`:
  - The output sequence is unchanged and there is one `done` only.
- `rst` asserted mid-SEND between edges:
  - `ch_valid`/`busy` drop immediately and `done` never pulses.
  - After release, a fresh `start` produces a correct full sequence.

Source files
------------

// File: rtl/string_serializer.sv
// Serializes a right-justified packed string MSB-first, one byte per valid/ready
// handshake, discarding leading NUL padding and pulsing done at the end of each job.
module string_serializer #(
    parameter int MAXCHARS = 80,
    parameter int CNTW     = $clog2(MAXCHARS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*MAXCHARS-1:0] str_in,
    output logic                  busy,
    output logic                  ch_valid,
    input  logic                  ch_ready,
    output logic [7:0]            ch_data,
    output logic                  ch_last,
    output logic                  done
);

    localparam int SRW = 8 * MAXCHARS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SKIP = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [SRW-1:0] sr_q, sr_d;
    logic [CNTW-1:0] rem_q, rem_d;
    logic [7:0]     top_byte;
    logic           rem_one;

    assign top_byte = sr_q[SRW-1 -: 8];
    assign rem_one  = (rem_q == CNTW'(1));

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d    = str_in;
                    rem_d   = CNTW'(MAXCHARS);
                    state_d = S_SKIP;
                end
            end
            S_SKIP: begin
                if (top_byte != 8'h00) begin
                    state_d = S_SEND;
                end else begin
                    sr_d  = {sr_q[SRW-9:0], 8'h00};
                    rem_d = rem_q - CNTW'(1);
                    // An all-NUL string exits here on its final byte
                    if (rem_one) state_d = S_DONE;
                end
            end
            S_SEND: begin
                if (ch_ready) begin
                    sr_d  = {sr_q[SRW-9:0], 8'h00};
                    rem_d = rem_q - CNTW'(1);
                    if (rem_one) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rem_q   <= rem_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign ch_valid = (state_q == S_SEND);
    assign ch_data  = ch_valid ? top_byte : 8'h00;
    assign ch_last  = ch_valid && rem_one;
    assign done     = (state_q == S_DONE);

endmodule
